// File: rtl/dti_fifo_async_pkg.sv
// Shared constants and helpers for the async FIFO pointer controllers.
package dti_fifo_async_pkg;

    localparam logic WrPeakRst    = 1'b0;
    localparam logic WrPeak2Rst   = 1'b1;
    localparam logic RdPeakRst    = 1'b1;
    localparam logic RdPeak2Rst   = 1'b0;
    localparam logic ProgFullRst  = 1'b0;
    localparam logic ProgEmptyRst = 1'b1;

    localparam int unsigned SyncStagesMin = 2;
    localparam int unsigned SyncStagesMax = 4;

    function automatic bit sync_stages_legal(input int unsigned n);
        return (n >= SyncStagesMin) && (n <= SyncStagesMax);
    endfunction

endpackage

// File: rtl/dti_bin_to_gray.sv
// Combinational binary-to-Gray converter.
module dti_bin_to_gray #(
    parameter int unsigned Width = 4
) (
    input  logic [Width-1:0] bin_i,
    output logic [Width-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/dti_gray_to_bin.sv
// Combinational Gray-to-binary converter.
module dti_gray_to_bin #(
    parameter int unsigned Width = 4
) (
    input  logic [Width-1:0] gray_i,
    output logic [Width-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < Width; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/dti_fifo_async_ptr_ctrl.sv
// Write- or read-side pointer, flag and level controller for an async FIFO.
// Define DTI_FIFO_ASYNC_PTR_CTRL_STICKY_ERR_EN for a sticky error cleared by err_clr.
module dti_fifo_async_ptr_ctrl
    import dti_fifo_async_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned WD_OR_RD    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic [ADDR_WIDTH:0]   gray_remote_ptr,
    input  logic [ADDR_WIDTH-1:0] prog_full_lvl,
    input  logic [ADDR_WIDTH-1:0] prog_empty_lvl,
    input  logic                  err_clr,
    output logic                  incr_ptr,
    output logic [ADDR_WIDTH-1:0] bin_addr,
    output logic [ADDR_WIDTH:0]   gray_ptr,
    output logic                  peak_state,
    output logic                  peak_state_2,
    output logic                  prog_full,
    output logic                  prog_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  error
);

    localparam int unsigned PW       = ADDR_WIDTH + 1;
    localparam bit          IsWrite  = (WD_OR_RD == 1);
    localparam logic        PeakRst  = IsWrite ? WrPeakRst : RdPeakRst;
    localparam logic        Peak2Rst = IsWrite ? WrPeak2Rst : RdPeak2Rst;

    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("SYNC_STAGES must lie in 2..4");
    end

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] sync_d [SYNC_STAGES];
    logic [PW-1:0] sync_ptr;
    logic [PW-1:0] sync_bin;
    logic [PW-1:0] bin_ptr_q, bin_ptr_d;
    logic [PW-1:0] gray_ptr_q, gray_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          peak_q, peak_d;
    logic          peak2_q, peak2_d;
    logic          prog_full_q, prog_full_d;
    logic          prog_empty_q, prog_empty_d;
    logic          error_q, error_d;
    logic          full_nx, empty_nx, violation;

`ifndef DTI_FIFO_ASYNC_PTR_CTRL_STICKY_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    assign sync_ptr = sync_q[SYNC_STAGES-1];

    dti_gray_to_bin #(
        .Width (PW)
    ) u_sync_g2b (
        .gray_i (sync_ptr),
        .bin_o  (sync_bin)
    );

    dti_bin_to_gray #(
        .Width (PW)
    ) u_next_b2g (
        .bin_i  (bin_ptr_d),
        .gray_o (gray_ptr_d)
    );

    always_comb begin
        sync_d[0] = gray_remote_ptr;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        incr_ptr  = req & ~peak_q;
        violation = req & peak_q;
        bin_ptr_d = bin_ptr_q + {{ADDR_WIDTH{1'b0}}, incr_ptr};

        // Full: the local pointer is one whole lap ahead of the remote one.
        full_nx  = (gray_ptr_d == {~sync_ptr[PW-1:PW-2], sync_ptr[PW-3:0]});
        empty_nx = (gray_ptr_d == sync_ptr);

        level_d      = IsWrite ? (bin_ptr_d - sync_bin) : (sync_bin - bin_ptr_d);
        peak_d       = IsWrite ? full_nx : empty_nx;
        peak2_d      = IsWrite ? empty_nx : full_nx;
        prog_full_d  = level_d > {1'b0, prog_full_lvl};
        prog_empty_d = level_d < {1'b0, prog_empty_lvl};

`ifdef DTI_FIFO_ASYNC_PTR_CTRL_STICKY_ERR_EN
        error_d = violation | (error_q & ~err_clr);
`else
        error_d = violation;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            bin_ptr_q    <= '0;
            gray_ptr_q   <= '0;
            level_q      <= '0;
            peak_q       <= PeakRst;
            peak2_q      <= Peak2Rst;
            prog_full_q  <= ProgFullRst;
            prog_empty_q <= ProgEmptyRst;
            error_q      <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            bin_ptr_q    <= bin_ptr_d;
            gray_ptr_q   <= gray_ptr_d;
            level_q      <= level_d;
            peak_q       <= peak_d;
            peak2_q      <= peak2_d;
            prog_full_q  <= prog_full_d;
            prog_empty_q <= prog_empty_d;
            error_q      <= error_d;
        end
    end

    assign bin_addr     = bin_ptr_q[ADDR_WIDTH-1:0];
    assign gray_ptr     = gray_ptr_q;
    assign level        = level_q;
    assign peak_state   = peak_q;
    assign peak_state_2 = peak2_q;
    assign prog_full    = prog_full_q;
    assign prog_empty   = prog_empty_q;
    assign error        = error_q;

endmodule

// File: tb/tb_dti_fifo_async_ptr_ctrl.sv
// Bench for a write-side and a read-side controller (ADDR_WIDTH=3, SYNC_STAGES=2).
module tb_dti_fifo_async_ptr_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic check_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Index 0 = read side, 1 = write side.
    logic       req_s     [2];
    logic [3:0] rem_s     [2];
    logic [3:0] rem_gray  [2];
    logic       clr_s     [2];
    logic [2:0] pfl_s     [2];
    logic [2:0] pel_s     [2];
    logic       o_incr    [2];
    logic [2:0] o_addr    [2];
    logic [3:0] o_gray    [2];
    logic       o_peak    [2];
    logic       o_peak2   [2];
    logic       o_pf      [2];
    logic       o_pe      [2];
    logic [3:0] o_level   [2];
    logic       o_err     [2];

    int   m_loc   [2];
    int   m_s1    [2];
    int   m_s2    [2];
    int   m_level [2];
    logic m_peak  [2];
    logic m_peak2 [2];
    logic m_pf    [2];
    logic m_pe    [2];
    logic m_err   [2];

    always #5 clk = ~clk;

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    assign rem_gray[0] = b2g(rem_s[0]);
    assign rem_gray[1] = b2g(rem_s[1]);

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dti_fifo_async_ptr_ctrl #(
            .ADDR_WIDTH  (3),
            .WD_OR_RD    (g),
            .SYNC_STAGES (2)
        ) u_dut (
            .clk             (clk),
            .reset_n         (reset_n),
            .req             (req_s[g]),
            .gray_remote_ptr (rem_gray[g]),
            .prog_full_lvl   (pfl_s[g]),
            .prog_empty_lvl  (pel_s[g]),
            .err_clr         (clr_s[g]),
            .incr_ptr        (o_incr[g]),
            .bin_addr        (o_addr[g]),
            .gray_ptr        (o_gray[g]),
            .peak_state      (o_peak[g]),
            .peak_state_2    (o_peak2[g]),
            .prog_full       (o_pf[g]),
            .prog_empty      (o_pe[g]),
            .level           (o_level[g]),
            .error           (o_err[g])
        );
    end

    // Model: occupancy as modular pointer distance, remote seen two cycles late.
    function automatic int nloc(input int loc, input logic rq, input logic pk);
        return (loc + ((rq && !pk) ? 1 : 0)) % 16;
    endfunction

    function automatic int lvl(input int side, input int loc, input int sy);
        return (side == 1) ? (loc - sy + 16) % 16 : (sy - loc + 16) % 16;
    endfunction

    function automatic int nlvl(input int s);
        return lvl(s, nloc(m_loc[s], req_s[s], m_peak[s]), m_s2[s]);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < 2; s++) begin
                m_loc[s]   <= 0;
                m_s1[s]    <= 0;
                m_s2[s]    <= 0;
                m_level[s] <= 0;
                m_peak[s]  <= (s == 0);
                m_peak2[s] <= (s == 1);
                m_pf[s]    <= 1'b0;
                m_pe[s]    <= 1'b1;
                m_err[s]   <= 1'b0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                m_loc[s]   <= nloc(m_loc[s], req_s[s], m_peak[s]);
                m_level[s] <= nlvl(s);
                m_peak[s]  <= (s == 1) ? (nlvl(s) == 8) : (nlvl(s) == 0);
                m_peak2[s] <= (s == 1) ? (nlvl(s) == 0) : (nlvl(s) == 8);
                m_pf[s]    <= nlvl(s) > int'(pfl_s[s]);
                m_pe[s]    <= nlvl(s) < int'(pel_s[s]);
`ifdef DTI_FIFO_ASYNC_PTR_CTRL_STICKY_ERR_EN
                m_err[s]   <= (req_s[s] && m_peak[s]) || (m_err[s] && !clr_s[s]);
`else
                m_err[s]   <= req_s[s] && m_peak[s];
`endif
                m_s1[s]    <= int'(rem_s[s]);
                m_s2[s]    <= m_s1[s];
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int s = 0; s < 2; s++) begin
                chk($sformatf("incr_ptr[%0d]", s), int'(o_incr[s]),
                    int'(req_s[s] && !m_peak[s]));
                chk($sformatf("bin_addr[%0d]", s), int'(o_addr[s]), m_loc[s] % 8);
                chk($sformatf("gray_ptr[%0d]", s), int'(o_gray[s]),
                    int'(b2g(4'(m_loc[s]))));
                chk($sformatf("peak[%0d]", s), int'(o_peak[s]), int'(m_peak[s]));
                chk($sformatf("peak2[%0d]", s), int'(o_peak2[s]), int'(m_peak2[s]));
                chk($sformatf("prog_full[%0d]", s), int'(o_pf[s]), int'(m_pf[s]));
                chk($sformatf("prog_empty[%0d]", s), int'(o_pe[s]), int'(m_pe[s]));
                chk($sformatf("level[%0d]", s), int'(o_level[s]), m_level[s]);
                chk($sformatf("error[%0d]", s), int'(o_err[s]), int'(m_err[s]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " wr level"}, int'(o_level[1]), 0);
        chk({tag, " wr gray"}, int'(o_gray[1]), 0);
        chk({tag, " wr addr"}, int'(o_addr[1]), 0);
        chk({tag, " wr peak"}, int'(o_peak[1]), 0);
        chk({tag, " wr peak2"}, int'(o_peak2[1]), 1);
        chk({tag, " wr prog_empty"}, int'(o_pe[1]), 1);
        chk({tag, " wr prog_full"}, int'(o_pf[1]), 0);
        chk({tag, " wr error"}, int'(o_err[1]), 0);
        chk({tag, " rd peak"}, int'(o_peak[0]), 1);
        chk({tag, " rd peak2"}, int'(o_peak2[0]), 0);
        chk({tag, " rd level"}, int'(o_level[0]), 0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_s[s] = 1'b0;
            rem_s[s] = 4'd0;
            clr_s[s] = 1'b0;
            pfl_s[s] = 3'd5;
            pel_s[s] = 3'd2;
        end
        #1 reset_n = 1'b0;
        check_en = 1'b1;
        step();
        chk_reset_vals("reset");
        reset_n = 1'b1;
        step();

        // Fill the write side with the remote pointer held at 0.
        req_s[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("fill level", int'(o_level[1]), k);
            if (k == 1) chk("prog_empty at 1", int'(o_pe[1]), 1);
            if (k == 2) chk("prog_empty at 2", int'(o_pe[1]), 0);
            if (k == 5) chk("prog_full at 5", int'(o_pf[1]), 0);
            if (k == 6) chk("prog_full at 6", int'(o_pf[1]), 1);
        end
        chk("full peak", int'(o_peak[1]), 1);
        chk("9th req incr", int'(o_incr[1]), 0);
        chk("full gray", int'(o_gray[1]), 4'b1100);
        step();
        chk("overflow error", int'(o_err[1]), 1);
        chk("gray held", int'(o_gray[1]), 4'b1100);
        req_s[1] = 1'b0;
        step();
`ifdef DTI_FIFO_ASYNC_PTR_CTRL_STICKY_ERR_EN
        chk("sticky error held", int'(o_err[1]), 1);
        req_s[1] = 1'b1;
        clr_s[1] = 1'b1;
        step();
        chk("clr with violation", int'(o_err[1]), 1);
        req_s[1] = 1'b0;
        step();
        chk("clr clears", int'(o_err[1]), 0);
        clr_s[1] = 1'b0;
`else
        chk("error pulse ends", int'(o_err[1]), 0);
`endif

        // Remote reader advances by one: full releases after the sync delay.
        rem_s[1] = 4'd1;
        step();
        chk("release +1", int'(o_peak[1]), 1);
        step();
        chk("release +2", int'(o_peak[1]), 1);
        step();
        chk("release +3", int'(o_peak[1]), 0);
        chk("release level", int'(o_level[1]), 7);

        // Asynchronous reset in the middle of a fill.
        reset_n = 1'b0;
        rem_s[1] = 4'd0;
        step();
        reset_n = 1'b1;
        req_s[1] = 1'b1;
        repeat (4) step();
        req_s[1] = 1'b0;
        chk("mid-fill level", int'(o_level[1]), 4);
        #1 reset_n = 1'b0;
        #1 chk_reset_vals("async reset");
        step();
        reset_n = 1'b1;
        step();

        // Read side: pop behind a slowly advancing remote writer up to 14.
        req_s[0] = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            rem_s[0] = 4'(i);
            step();
            step();
        end
        repeat (8) step();
        req_s[0] = 1'b0;
        chk("rd empty at 14", int'(o_peak[0]), 1);
        chk("rd addr at 14", int'(o_addr[0]), 6);
        chk("rd gray at 14", int'(o_gray[0]), 4'b1001);
        rem_s[0] = 4'd15;
        repeat (3) step();
        chk("rd level rem 15", int'(o_level[0]), 1);
        rem_s[0] = 4'd0;
        repeat (3) step();
        chk("rd level wrap", int'(o_level[0]), 2);
        chk("rd no empty", int'(o_peak[0]), 0);
        chk("rd no full", int'(o_peak2[0]), 0);
        chk("rd prog_empty at 2", int'(o_pe[0]), 0);
        step();

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dti_fifo_async_ptr_ctrl.md
DTI_FIFO_ASYNC_PTR_CTRL -- requirements
Module: dti_fifo_async_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: address width; DEPTH = 2^ADDR_WIDTH, legal range 2..12.
REQ-002 SHALL have parameter WD_OR_RD, default 1: 1 = write-side controller, 0 = read-side controller.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: remote-pointer synchroniser depth, legal range 2..4.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  1  push (write side) or pop (read side) request.
REQ-007 SHALL have port gray_remote_ptr  input  ADDR_WIDTH+1  Gray pointer from the other clock domain, unsynchronised.
REQ-008 SHALL have port prog_full_lvl  input  ADDR_WIDTH  programmable-full threshold.
REQ-009 SHALL have port prog_empty_lvl  input  ADDR_WIDTH  programmable-empty threshold.
REQ-010 SHALL have port err_clr  input  1  clears sticky error; used only with the Configuration macro.
REQ-011 SHALL have port incr_ptr  output  1  request granted this cycle.
REQ-012 SHALL have port bin_addr  output  ADDR_WIDTH  registered RAM address, the local pointer's low bits.
REQ-013 SHALL have port gray_ptr  output  ADDR_WIDTH+1  registered local Gray pointer, sent to the other domain.
REQ-014 SHALL have port peak_state  output  1  full (write side) or empty (read side).
REQ-015 SHALL have port peak_state_2  output  1  empty (write side) or full (read side).
REQ-016 SHALL have port prog_full, prog_empty  output  1 each  programmable flags.
REQ-017 SHALL have port level  output  ADDR_WIDTH+1  registered occupancy, 0..DEPTH.
REQ-018 SHALL have port error  output  1  request made while peak_state is asserted.

Function
REQ-019 SHALL pass gray_remote_ptr through SYNC_STAGES flops clocked by clk; the last stage is sync_ptr.
REQ-020 SHALL assert incr_ptr = req & ~peak_state combinationally.
REQ-021 SHALL hold a binary local pointer of width ADDR_WIDTH+1 that increments by 1 per incr_ptr and wraps from 2^(ADDR_WIDTH+1)-1 to 0.
REQ-022 SHALL register gray_ptr as the binary-to-Gray conversion of the next binary pointer, so gray_ptr changes exactly one bit per increment.
REQ-023 SHALL compute all flags and level from the next local pointer and the current sync_ptr, registered, so that flags are valid the cycle after a grant.
REQ-024 SHALL compute level as (local - bin(sync_ptr)) mod 2^(ADDR_WIDTH+1) on the write side, and (bin(sync_ptr) - local) on the read side.
REQ-025 SHALL assert full when the next Gray pointer equals sync_ptr with its top two bits inverted; empty when it equals sync_ptr.
REQ-026 SHALL set prog_full = level_nx > prog_full_lvl and prog_empty = level_nx < prog_empty_lvl.
REQ-027 SHALL never grant a request while peak_state is asserted, so the pointer never passes full or empty.
REQ-028 SHALL release flags only through sync_ptr movement; the release latency is SYNC_STAGES+1 remote-to-local cycles.

Reset
REQ-029 SHALL on reset_n low clear the local pointer, gray_ptr, bin_addr, all synchroniser stages, level, error and prog_full, and set prog_empty to 1.
REQ-030 SHALL reset the write side to peak_state=0, peak_state_2=1, and the read side to peak_state=1, peak_state_2=0.

Configuration
REQ-031 SHALL, with DTI_FIFO_ASYNC_PTR_CTRL_STICKY_ERR_EN undefined, register error = req & peak_state, giving a one-cycle pulse, and ignore err_clr.
REQ-032 SHALL, with DTI_FIFO_ASYNC_PTR_CTRL_STICKY_ERR_EN defined, hold error at 1 from the first violation until an err_clr cycle with no new violation; a violation in the same cycle as err_clr keeps error at 1.

Structure
REQ-033 SHALL place the reset-value constants and the function for the legal SYNC_STAGES range in package dti_fifo_async_pkg.
REQ-034 SHALL reuse the existing dti_gray_to_bin for sync_ptr conversion and instantiate one new sub-module, dti_bin_to_gray.

Verification (ADDR_WIDTH=3, SYNC_STAGES=2)
REQ-035 Write side, remote pointer held 0, 8 back-to-back req -> 8 grants; peak_state=1 the cycle after the 8th grant; level=8.
REQ-036 Full write side, 9th req -> incr_ptr=0, gray_ptr unchanged; error pulses 1 cycle (macro off) or stays high until err_clr (macro on).
REQ-037 Full write side, remote Gray advances by 1 -> peak_state deasserts 3 cycles later; level=7.
REQ-038 Read side, remote pointer wraps past 15 to 0 with local at 14 -> level computed modulo 16, no false full or empty.
REQ-039 prog_full_lvl=5, prog_empty_lvl=2 -> prog_full asserts at level 6, prog_empty deasserts at level 2.
REQ-040 reset_n asserted mid-fill at level 4 -> all outputs take their reset values immediately, asynchronously.
